// File: rtl/sha_wb_ctrl.sv
// ---------------------------------------------------------------------------
// sha_wb_ctrl
//
// Wishbone front-end for an external SHA-256 core. The CPU pushes message
// words into an input FIFO. An autonomous feeder FSM hands them to the core
// in 16-word blocks. A status register, a completed-block counter, a
// maskable interrupt and auto-incrementing hash readback complete the
// register map.
//
// Register map (byte addresses):
//   0x00  W: bit0 init (flush + restart), bit2 reload IV into CORE_HX
//         R: {level[15:8], irq_pend[5], ovf[4], full[3], empty[2], done[1], busy[0]}
//   0x04  W: push a message word into the FIFO
//   0x08  R: hash word hash_idx of CORE_HASH_I, then hash_idx advances (wraps 7->0)
//   0x0C  W: shift a word into CORE_HX from the bottom (ignored while busy)
//   0x10  W: bit0 irq_en, bit1 clear irq_pend, bit2 clear ovf
//         R: {ovf, irq_pend, irq_en}
//   0x14  R: completed-block counter
//
// Ports:
//   CLK_I, RST_N_I        clock, asynchronous active-low reset
//   SHA_STB_I/WE_I/ADR_I/DAT_I   Wishbone slave inputs
//   SHA_ACK_O/DAT_O/ERR_O/RTY_O  Wishbone slave outputs (ERR/RTY tied low)
//   IRQ_O                 level interrupt, irq_pend & irq_en
//   CORE_INIT_O/VLD_O/DIN_O/HX_O drive the SHA core
//   CORE_DONE_I/HASH_I    results from the SHA core
// ---------------------------------------------------------------------------
module sha_wb_ctrl #(
   parameter int FIFO_AW   = 5,
   parameter int BLK_WORDS = 16,
   parameter int CNT_W     = 16
) (
   input  logic         CLK_I,
   input  logic         RST_N_I,
   input  logic         SHA_STB_I,
   input  logic         SHA_WE_I,
   input  logic [4:0]   SHA_ADR_I,
   input  logic [31:0]  SHA_DAT_I,
   output logic         SHA_ACK_O,
   output logic [31:0]  SHA_DAT_O,
   output logic         SHA_ERR_O,
   output logic         SHA_RTY_O,
   output logic         IRQ_O,
   output logic         CORE_INIT_O,
   output logic         CORE_VLD_O,
   output logic [31:0]  CORE_DIN_O,
   output logic [255:0] CORE_HX_O,
   input  logic         CORE_DONE_I,
   input  logic [255:0] CORE_HASH_I
);

   localparam int DEPTH  = 1 << FIFO_AW;
   localparam int LVL_W  = FIFO_AW + 1;
   localparam int WCNT_W = (BLK_WORDS > 1) ? $clog2(BLK_WORDS) : 1;

   localparam logic [255:0] SHA_IV = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   typedef enum logic [1:0] {
      StIdle,
      StFeed,
      StWait
   } state_e;

   state_e              state_q, state_d;
   logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
   logic                doneEvt;

   logic                ack_q;
   logic [31:0]         dat_q;
   logic [31:0]         rdData;

   logic [31:0]         mem [DEPTH];
   logic [FIFO_AW-1:0]  wrPtr_q, rdPtr_q;
   logic [LVL_W-1:0]    level_q;

   logic                coreInit_q;
   logic                coreVld_q;
   logic [31:0]         coreDin_q;
   logic [255:0]        hx_q;

   logic                done_q;
   logic                ovf_q;
   logic                irqPend_q;
   logic                irqEn_q;
   logic [CNT_W-1:0]    blkCnt_q;
   logic [2:0]          hashIdx_q;

   // Bus decode: every side effect happens on the STB & ~ACK cycle only.
   logic access, wrAcc, rdAcc;
   logic initCmd, ivCmd, dinWr, hxWr, ctrlWr, hashRd;
   logic fifoFull, fifoEmpty, push, pop, dropped, busy;

   assign access  = SHA_STB_I & ~ack_q;
   assign wrAcc   = access & SHA_WE_I;
   assign rdAcc   = access & ~SHA_WE_I;
   assign initCmd = wrAcc & (SHA_ADR_I == 5'h00) & SHA_DAT_I[0];
   assign ivCmd   = wrAcc & (SHA_ADR_I == 5'h00) & SHA_DAT_I[2];
   assign dinWr   = wrAcc & (SHA_ADR_I == 5'h04);
   assign hxWr    = wrAcc & (SHA_ADR_I == 5'h0C);
   assign ctrlWr  = wrAcc & (SHA_ADR_I == 5'h10);
   assign hashRd  = rdAcc & (SHA_ADR_I == 5'h08);

   assign busy      = (state_q != StIdle);
   assign fifoFull  = (level_q == LVL_W'(DEPTH));
   assign fifoEmpty = (level_q == '0);

   // Fullness is judged on the registered level, before any same-cycle pop,
   // and init discards a push because it flushes the FIFO anyway.
   assign push    = dinWr & ~fifoFull & ~initCmd;
   assign dropped = dinWr & fifoFull & ~initCmd;
   assign pop     = (state_q == StFeed) & ~initCmd;

   // Feeder FSM state register.
   always_ff @(posedge CLK_I or negedge RST_N_I) begin
      if (!RST_N_I) begin
         state_q <= StIdle;
         wcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
      end
   end

   // Feeder FSM next state. A block is only started once a full block is
   // already buffered, so FEED never has to stall for data. Init aborts
   // whatever the feeder is doing and swallows a coincident core done.
   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      doneEvt = 1'b0;
      case (state_q)
         StIdle: begin
            if (level_q >= LVL_W'(BLK_WORDS)) begin
               state_d = StFeed;
               wcnt_d  = '0;
            end
         end
         StFeed: begin
            if (wcnt_q == WCNT_W'(BLK_WORDS - 1)) begin
               state_d = StWait;
               wcnt_d  = '0;
            end else begin
               wcnt_d = wcnt_q + 1'b1;
            end
         end
         StWait: begin
            if (CORE_DONE_I) begin
               state_d = StIdle;
               doneEvt = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
      if (initCmd) begin
         state_d = StIdle;
         wcnt_d  = '0;
         doneEvt = 1'b0;
      end
   end

   // FIFO storage has no reset; only the pointers and level matter.
   always_ff @(posedge CLK_I) begin
      if (push) begin
         mem[wrPtr_q] <= SHA_DAT_I;
      end
   end

   // FIFO pointers and fill level; init flushes everything.
   always_ff @(posedge CLK_I or negedge RST_N_I) begin
      if (!RST_N_I) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         level_q <= '0;
      end else if (initCmd) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         level_q <= '0;
      end else begin
         if (push) wrPtr_q <= wrPtr_q + 1'b1;
         if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
         case ({push, pop})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
      end
   end

   // Core-side outputs: the popped word is presented one cycle after the pop.
   always_ff @(posedge CLK_I or negedge RST_N_I) begin
      if (!RST_N_I) begin
         coreInit_q <= 1'b0;
         coreVld_q  <= 1'b0;
         coreDin_q  <= '0;
         hx_q       <= SHA_IV;
      end else begin
         coreInit_q <= initCmd;
         coreVld_q  <= pop;
         if (pop) coreDin_q <= mem[rdPtr_q];
         if (ivCmd) begin
            hx_q <= SHA_IV;
         end else if (hxWr && !busy) begin
            hx_q <= {hx_q[223:0], SHA_DAT_I};
         end
      end
   end

   // Status flags, interrupt and counters. Setting events win over
   // same-cycle software clears so a completion is never lost.
   always_ff @(posedge CLK_I or negedge RST_N_I) begin
      if (!RST_N_I) begin
         done_q    <= 1'b0;
         ovf_q     <= 1'b0;
         irqPend_q <= 1'b0;
         irqEn_q   <= 1'b0;
         blkCnt_q  <= '0;
         hashIdx_q <= '0;
      end else begin
         if (initCmd)      done_q <= 1'b0;
         else if (doneEvt) done_q <= 1'b1;
         else if (dinWr)   done_q <= 1'b0;

         if (dropped)                      ovf_q <= 1'b1;
         else if (ctrlWr && SHA_DAT_I[2])  ovf_q <= 1'b0;

         if (doneEvt)                      irqPend_q <= 1'b1;
         else if (ctrlWr && SHA_DAT_I[1])  irqPend_q <= 1'b0;

         if (ctrlWr) irqEn_q <= SHA_DAT_I[0];

         if (initCmd)                    blkCnt_q <= '0;
         else if (doneEvt && !(&blkCnt_q)) blkCnt_q <= blkCnt_q + 1'b1;

         if (initCmd)     hashIdx_q <= '0;
         else if (hashRd) hashIdx_q <= hashIdx_q + 1'b1;
      end
   end

   // Read mux. The level field is 8 bits wide; the deepest FIFO (256 words)
   // would overflow it, so that single case reads as 0xFF.
   always_comb begin
      logic [8:0]   level9;
      logic [7:0]   levelByte;
      logic [255:0] hashSh;
      level9    = 9'(level_q);
      levelByte = level9[8] ? 8'hFF : level9[7:0];
      hashSh    = CORE_HASH_I << (32 * hashIdx_q);
      rdData    = '0;
      case (SHA_ADR_I)
         5'h00:   rdData = {16'b0, levelByte, 2'b0, irqPend_q, ovf_q,
                            fifoFull, fifoEmpty, done_q, busy};
         5'h08:   rdData = hashSh[255:224];
         5'h10:   rdData = {29'b0, ovf_q, irqPend_q, irqEn_q};
         5'h14:   rdData = 32'(blkCnt_q);
         default: rdData = '0;
      endcase
   end

   // Wishbone handshake: single-cycle ACK, read data registered alongside it.
   always_ff @(posedge CLK_I or negedge RST_N_I) begin
      if (!RST_N_I) begin
         ack_q <= 1'b0;
         dat_q <= '0;
      end else begin
         ack_q <= access;
         if (rdAcc)       dat_q <= rdData;
         else if (access) dat_q <= '0;
      end
   end

   assign SHA_ACK_O   = ack_q;
   assign SHA_DAT_O   = dat_q;
   assign SHA_ERR_O   = 1'b0;
   assign SHA_RTY_O   = 1'b0;
   assign IRQ_O       = irqPend_q & irqEn_q;
   assign CORE_INIT_O = coreInit_q;
   assign CORE_VLD_O  = coreVld_q;
   assign CORE_DIN_O  = coreDin_q;
   assign CORE_HX_O   = hx_q;

endmodule

// File: tb/tb_sha_wb_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sha_wb_ctrl
//
// Self-checking bench for sha_wb_ctrl. Bus accesses push their expected
// read data into a scoreboard queue and expected core words into a second
// queue; a monitor pops and compares whenever ACK or CORE_VLD is seen.
// ---------------------------------------------------------------------------
module tb_sha_wb_ctrl;

   localparam logic [255:0] IV = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   typedef struct {
      bit          isRead;
      logic [31:0] exp;
      string       name;
   } busExp_t;

   logic         clk;
   logic         rstN;
   logic         stb;
   logic         we;
   logic [4:0]   adr;
   logic [31:0]  datI;
   logic         ack;
   logic [31:0]  datO;
   logic         err;
   logic         rty;
   logic         irq;
   logic         coreInit;
   logic         coreVld;
   logic [31:0]  coreDin;
   logic [255:0] coreHx;
   logic         coreDone;
   logic [255:0] coreHash;

   int checks;
   int failures;
   int initPulses;
   int vldRun;
   int vldRunMax;

   busExp_t     busQ[$];
   logic [31:0] dinQ[$];
   busExp_t     monE;
   logic [31:0] monD;

   sha_wb_ctrl #(.FIFO_AW(5), .BLK_WORDS(16), .CNT_W(16)) dut (
      .CLK_I       (clk),
      .RST_N_I     (rstN),
      .SHA_STB_I   (stb),
      .SHA_WE_I    (we),
      .SHA_ADR_I   (adr),
      .SHA_DAT_I   (datI),
      .SHA_ACK_O   (ack),
      .SHA_DAT_O   (datO),
      .SHA_ERR_O   (err),
      .SHA_RTY_O   (rty),
      .IRQ_O       (irq),
      .CORE_INIT_O (coreInit),
      .CORE_VLD_O  (coreVld),
      .CORE_DIN_O  (coreDin),
      .CORE_HX_O   (coreHx),
      .CORE_DONE_I (coreDone),
      .CORE_HASH_I (coreHash)
   );

   // 100 MHz clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog so the run always ends.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Monitor: pops the scoreboards whenever the DUT presents ACK or CORE_VLD,
   // and tracks init pulses and VLD run lengths.
   always @(negedge clk) begin
      if (rstN) begin
         if (ack) begin
            if (busQ.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL unexpected_ack actual=ack required=no_ack");
            end else begin
               monE = busQ.pop_front();
               if (monE.isRead) begin
                  checks++;
                  if (datO !== monE.exp) begin
                     failures++;
                     $display("[TB] FAIL %s actual=%h required=%h", monE.name, datO, monE.exp);
                  end
               end
            end
         end
         if (coreVld) begin
            vldRun++;
            if (vldRun > vldRunMax) vldRunMax = vldRun;
            checks++;
            if (dinQ.size() == 0) begin
               failures++;
               $display("[TB] FAIL core_din actual=%h required=no_vld", coreDin);
            end else begin
               monD = dinQ.pop_front();
               if (coreDin !== monD) begin
                  failures++;
                  $display("[TB] FAIL core_din actual=%h required=%h", coreDin, monD);
               end
            end
         end else begin
            vldRun = 0;
         end
         if (coreInit) initPulses++;
      end
   end

   // Direct comparison for outputs that are not bus/core transactions.
   task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // One Wishbone access; optionally pulses CORE_DONE_I on the access edge.
   task automatic applyStimulus(input bit wr, input logic [4:0] a, input logic [31:0] d,
                                input logic [31:0] exp, input string name, input bit withDone);
      busExp_t e;
      int t;
      e.isRead = !wr;
      e.exp    = exp;
      e.name   = name;
      busQ.push_back(e);
      @(negedge clk);
      stb  = 1'b1;
      we   = wr;
      adr  = a;
      datI = d;
      if (withDone) coreDone = 1'b1;
      t = 0;
      do begin
         @(posedge clk);
         #1;
         coreDone = 1'b0;
         t++;
      end while (!ack && t < 8);
      stb = 1'b0;
      we  = 1'b0;
      if (!ack) begin
         checks++;
         failures++;
         $display("[TB] FAIL ack_timeout_%s actual=0 required=1", name);
         void'(busQ.pop_back());
      end
   endtask

   task automatic wbWrite(input logic [4:0] a, input logic [31:0] d);
      applyStimulus(1'b1, a, d, 32'h0, "write", 1'b0);
   endtask

   task automatic wbRead(input logic [4:0] a, input logic [31:0] exp, input string name);
      applyStimulus(1'b0, a, 32'h0, exp, name, 1'b0);
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulseDone();
      @(negedge clk);
      coreDone = 1'b1;
      @(negedge clk);
      coreDone = 1'b0;
   endtask

   // Push 16 words base+i and expect all of them on the core interface.
   task automatic sendBlock(input logic [31:0] base);
      for (int i = 0; i < 16; i++) dinQ.push_back(base + 32'(i));
      for (int i = 0; i < 16; i++) wbWrite(5'h04, base + 32'(i));
   endtask

   initial begin
      int seen;
      int t;
      int initBase;
      logic [255:0] hxExp;

      checks     = 0;
      failures   = 0;
      initPulses = 0;
      vldRun     = 0;
      vldRunMax  = 0;
      rstN       = 1'b0;
      stb        = 1'b0;
      we         = 1'b0;
      adr        = '0;
      datI       = '0;
      coreDone   = 1'b0;
      coreHash   = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};

      // Reset values while reset is held.
      waitCycles(3);
      checkOutput("rst_ack",  256'(ack), 256'(0));
      checkOutput("rst_irq",  256'(irq), 256'(0));
      checkOutput("rst_init", 256'(coreInit), 256'(0));
      checkOutput("rst_vld",  256'(coreVld), 256'(0));
      checkOutput("rst_din",  256'(coreDin), 256'(0));
      checkOutput("rst_dato", 256'(datO), 256'(0));
      checkOutput("rst_hx",   coreHx, IV);
      rstN = 1'b1;
      waitCycles(2);
      wbRead(5'h00, 32'h0000_0004, "rst_status");
      wbRead(5'h14, 32'h0000_0000, "rst_blkcnt");
      wbRead(5'h10, 32'h0000_0000, "rst_ctrl");
      wbRead(5'h18, 32'h0000_0000, "unmapped_rd");

      // Basic block: init, 16 words, core done.
      wbWrite(5'h00, 32'h1);
      waitCycles(2);
      checkOutput("init_pulse", 256'(initPulses), 256'(1));
      sendBlock(32'h0);
      waitCycles(25);
      wbRead(5'h00, 32'h0000_0005, "blk_busy");
      checkOutput("vld_run", 256'(vldRunMax), 256'(16));
      pulseDone();
      wbRead(5'h00, 32'h0000_0026, "blk_done_status");
      wbRead(5'h14, 32'h0000_0001, "blk_cnt1");
      wbRead(5'h10, 32'h0000_0002, "pend_no_en");
      checkOutput("irq_masked", 256'(irq), 256'(0));
      wbWrite(5'h10, 32'h2);
      wbRead(5'h00, 32'h0000_0006, "status_after_clr");

      // Interrupt enabled.
      wbWrite(5'h10, 32'h1);
      sendBlock(32'h100);
      waitCycles(25);
      pulseDone();
      waitCycles(1);
      checkOutput("irq_set", 256'(irq), 256'(1));
      wbRead(5'h10, 32'h0000_0003, "ctrl_en_pend");
      wbWrite(5'h10, 32'h3);
      checkOutput("irq_clr", 256'(irq), 256'(0));
      wbRead(5'h10, 32'h0000_0001, "ctrl_en_only");
      wbWrite(5'h10, 32'h0);

      // Done coincident with an irq_pend clear: the pend stays set.
      sendBlock(32'h200);
      waitCycles(25);
      applyStimulus(1'b1, 5'h10, 32'h2, 32'h0, "clr_with_done", 1'b1);
      wbRead(5'h10, 32'h0000_0002, "pend_wins");
      checkOutput("irq_disabled", 256'(irq), 256'(0));
      wbRead(5'h14, 32'h0000_0003, "blk_cnt3");
      wbWrite(5'h04, 32'hAAAA_5555);
      wbRead(5'h00, 32'h0000_0120, "din_clears_done");
      wbWrite(5'h10, 32'h2);
      wbWrite(5'h00, 32'h1);
      wbRead(5'h00, 32'h0000_0004, "flush_status");
      wbRead(5'h14, 32'h0000_0000, "init_clr_cnt");

      // Hash readback with wrap.
      for (int i = 0; i < 9; i++) wbRead(5'h08, 32'((i % 8) + 1), "hash_rd");

      // Overflow: one block parked in WAIT, then fill the FIFO and overrun.
      sendBlock(32'h300);
      waitCycles(25);
      for (int i = 16; i < 33; i++) wbWrite(5'h04, 32'h300 + 32'(i));
      wbRead(5'h00, 32'h0000_1101, "level17");
      for (int i = 33; i < 48; i++) wbWrite(5'h04, 32'h300 + 32'(i));
      wbRead(5'h00, 32'h0000_2009, "level32_full");
      wbWrite(5'h04, 32'h330);
      wbRead(5'h00, 32'h0000_2019, "ovf_set");
      wbRead(5'h10, 32'h0000_0004, "ovf_ctrl");
      wbWrite(5'h10, 32'h4);
      wbRead(5'h00, 32'h0000_2009, "ovf_clr");
      for (int i = 16; i < 32; i++) dinQ.push_back(32'h300 + 32'(i));
      pulseDone();
      waitCycles(25);
      wbRead(5'h00, 32'h0000_1023, "second_block_wait");

      // Init in the middle of FEED.
      wbWrite(5'h00, 32'h1);
      wbWrite(5'h10, 32'h2);
      wbRead(5'h00, 32'h0000_0004, "pre_abort");
      initBase = initPulses;
      for (int i = 0; i < 6; i++) dinQ.push_back(32'h400 + 32'(i));
      for (int i = 0; i < 16; i++) wbWrite(5'h04, 32'h400 + 32'(i));
      seen = 0;
      t    = 0;
      while (seen < 5 && t < 100) begin
         @(negedge clk);
         if (coreVld) seen++;
         t++;
      end
      checkOutput("feed_started", 256'(seen), 256'(5));
      wbWrite(5'h00, 32'h1);
      waitCycles(3);
      checkOutput("abort_vld", 256'(coreVld), 256'(0));
      checkOutput("abort_init_pulse", 256'(initPulses - initBase), 256'(1));
      wbRead(5'h00, 32'h0000_0004, "abort_status");

      // CORE_HX shifting, busy lockout and IV reload.
      hxExp = '0;
      for (int k = 0; k < 8; k++) begin
         wbWrite(5'h0C, 32'h1000_0000 + 32'(k));
         hxExp = {hxExp[223:0], 32'h1000_0000 + 32'(k)};
      end
      checkOutput("hx_shift", coreHx, hxExp);
      sendBlock(32'h500);
      waitCycles(25);
      wbWrite(5'h0C, 32'hDEAD_BEEF);
      checkOutput("hx_busy_ignored", coreHx, hxExp);
      wbWrite(5'h00, 32'h4);
      checkOutput("hx_iv_reload", coreHx, IV);
      wbRead(5'h00, 32'h0000_0005, "final_busy");
      pulseDone();
      waitCycles(3);

      checkOutput("bus_queue_empty", 256'(busQ.size()), 256'(0));
      checkOutput("din_queue_empty", 256'(dinQ.size()), 256'(0));
      checkOutput("err_rty", 256'({err, rty}), 256'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
